upsample4x_line_replicator: RTL

Single-clock 4x nearest-neighbour upsampler. It sits at the output of the octave/DoG pipeline and expands a WIDTH x HEIGHT stream back to display resolution. Each input pixel is repeated 4 times horizontally and each input line 4 times vertically. Input lines are held in a ping-pong pair of line buffers, so one line can be captured while the previous line is replayed. Both ends use valid/ready handshakes.

---
 rtl/upsample4x_line_replicator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/upsample4x_line_replicator.sv
// 4x nearest-neighbour upsampler: ping-pong line buffers, each pixel and
// each line replayed four times, valid/ready on both ends.
module upsample4x_line_replicator #(
   parameter int WIDTH  = 210,
   parameter int HEIGHT = 120
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       valid,
   output logic       ready,
   output logic [7:0] dout,
   output logic       validout,
   input  logic       out_ready,
   output logic [9:0] rowcount,
   output logic [9:0] colcount
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] WCOL_LAST = CW'(WIDTH - 1);
   localparam logic [9:0]    OCOL_LAST = 10'(4 * WIDTH - 1);
   localparam logic [9:0]    OROW_LAST = 10'(4 * HEIGHT - 1);

   typedef enum logic {IDLE, EMIT} state_t;

   logic [7:0]    bank0 [WIDTH];
   logic [7:0]    bank1 [WIDTH];
   logic [1:0]    full;
   logic          wbank;
   logic          rbank;
   logic [CW-1:0] wcol;
   state_t        state;
   state_t        state_next;
   logic [9:0]    ocol;
   logic [9:0]    orow;
   logic [1:0]    rep;
   logic          accept;
   logic          line_done;
   logic          step;
   logic          release_bank;
   logic [CW-1:0] ridx;
   logic [7:0]    pix;

   assign ready     = !full[wbank];
   assign accept    = valid && ready;
   assign line_done = accept && (wcol == WCOL_LAST);
   assign ridx      = CW'(ocol >> 2);
   assign pix       = rbank ? bank1[ridx] : bank0[ridx];

   // Line buffer storage; contents need no reset since full flags gate use.
   always_ff @(posedge clock) begin
      if (accept) begin
         if (wbank) bank1[wcol] <= din;
         else       bank0[wcol] <= din;
      end
   end

   // Write column and write bank pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wcol  <= '0;
         wbank <= 1'b0;
      end else if (accept) begin
         if (line_done) begin
            wcol  <= '0;
            wbank <= ~wbank;
         end else begin
            wcol <= wcol + 1'b1;
         end
      end
   end

   // Full flags: set by writer at line end, cleared by reader after the 4th
   // replay; a set and a clear on one edge always target different banks.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full <= '0;
      end else begin
         if (line_done)    full[wbank] <= 1'b1;
         if (release_bank) full[rbank] <= 1'b0;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Read FSM next state, pixel advance and bank release.
   always_comb begin
      state_next   = state;
      step         = 1'b0;
      release_bank = 1'b0;
      case (state)
         IDLE: begin
            if (full[rbank]) state_next = EMIT;
         end
         EMIT: begin
            step = !validout || out_ready;
            if (step && (ocol == OCOL_LAST) && (rep == 2'd3)) begin
               release_bank = 1'b1;
               state_next   = full[~rbank] ? EMIT : IDLE;
            end
         end
      endcase
   end

   // Output column, replay count, output row and read bank.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ocol  <= '0;
         orow  <= '0;
         rep   <= '0;
         rbank <= 1'b0;
      end else begin
         if (step) begin
            if (ocol == OCOL_LAST) begin
               ocol <= '0;
               rep  <= rep + 1'b1;
               orow <= (orow == OROW_LAST) ? '0 : orow + 1'b1;
            end else begin
               ocol <= ocol + 1'b1;
            end
         end
         if (release_bank) rbank <= ~rbank;
      end
   end

   // Output register: load on advance, drop valid once taken, hold when stalled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dout     <= '0;
         validout <= 1'b0;
         rowcount <= '0;
         colcount <= '0;
      end else if (step) begin
         dout     <= pix;
         validout <= 1'b1;
         rowcount <= orow;
         colcount <= ocol;
      end else if (out_ready) begin
         validout <= 1'b0;
      end
   end

endmodule
